// File: rtl/matmult_pkg.sv
// Shared constants and types for the Strassen operand loader.
// Element slot indices follow the fixed serial word order a11..b22.
package matmult_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int HOLD_W        = 8;
  localparam int NUM_ELEMS     = 8;
  localparam int IDX_W         = 3;

  localparam int IDX_A11 = 0;
  localparam int IDX_A12 = 1;
  localparam int IDX_A21 = 2;
  localparam int IDX_A22 = 3;
  localparam int IDX_B11 = 4;
  localparam int IDX_B12 = 5;
  localparam int IDX_B21 = 6;
  localparam int IDX_B22 = 7;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } fill_state_t;

endpackage

// File: rtl/matmult_loader_bank.sv
// Fill buffer: 8 x WIDTH register file, one indexed write port, all entries read in parallel.
// Written one cycle after the handshake; no backpressure of its own.
module loader_bank
  import matmult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en_i,
  input  logic [IDX_W-1:0]                    wr_idx_i,
  input  logic [WIDTH-1:0]                    wr_data_i,
  output logic [NUM_ELEMS-1:0][WIDTH-1:0]     rd_all_o
);

  logic [NUM_ELEMS-1:0][WIDTH-1:0] slot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_all_o = slot_q;

endmodule

// File: rtl/matmult_loader.sv
// Serial-to-parallel operand loader for the 2x2 Strassen multiplier; 1 cycle from 8th accept to transfer.
// in_ready drops while a complete set waits for the hold window to reach its last cycle.
module matmult_loader
  import matmult_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a11,
  output logic [WIDTH-1:0] a12,
  output logic [WIDTH-1:0] a21,
  output logic [WIDTH-1:0] a22,
  output logic [WIDTH-1:0] b11,
  output logic [WIDTH-1:0] b12,
  output logic [WIDTH-1:0] b21,
  output logic [WIDTH-1:0] b22,
  output logic             op_valid,
  output logic             start,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ELEMS - 1);

  fill_state_t                     state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [HOLD_W-1:0]               hold_cnt_q, hold_cnt_d;
  logic                            start_q, start_d;
  logic [NUM_ELEMS-1:0][WIDTH-1:0] ops_q, ops_d;
  logic [NUM_ELEMS-1:0][WIDTH-1:0] bank_rd;
  logic                            accept;
  logic                            xfer;

  assign in_ready = (state_q == ST_FILLING);
  assign accept   = in_valid && in_ready;
  // A waiting set may move in on the last hold cycle so op_valid never drops between sets.
  assign xfer     = (state_q == ST_FULL) &&
                    ((hold_cnt_q == '0) || (hold_cnt_q == HOLD_W'(1)));

  loader_bank #(.WIDTH(WIDTH)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_data),
    .rd_all_o  (bank_rd)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    ops_d      = ops_q;
    start_d    = 1'b0;

    unique case (state_q)
      ST_FILLING: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d = ST_FILLING;
        end
      end
      default: state_d = ST_FILLING;
    endcase

    if (xfer) begin
      ops_d      = bank_rd;
      hold_cnt_d = HOLD_LOAD;
      start_d    = 1'b1;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FILLING;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      start_q    <= 1'b0;
      ops_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      start_q    <= start_d;
      ops_q      <= ops_d;
    end
  end

  assign op_valid = (hold_cnt_q != '0);
  assign start    = start_q;
  assign busy     = (idx_q != '0) || (state_q == ST_FULL) || op_valid;

  assign a11 = ops_q[IDX_A11];
  assign a12 = ops_q[IDX_A12];
  assign a21 = ops_q[IDX_A21];
  assign a22 = ops_q[IDX_A22];
  assign b11 = ops_q[IDX_B11];
  assign b12 = ops_q[IDX_B12];
  assign b21 = ops_q[IDX_B21];
  assign b22 = ops_q[IDX_B22];

endmodule

// File: tb/tb_matmult_loader.sv
// Bench for matmult_loader: two instances (hold 4 and hold 12) checked against a set/transfer-time model.
module tb_matmult_loader;

  localparam int W    = 32;
  localparam int NDUT = 2;
  localparam int H0   = 4;
  localparam int H1   = 12;
  localparam int MAXW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] in_data  [NDUT];
  logic         in_valid [NDUT];
  logic         in_ready [NDUT];
  logic         op_valid [NDUT];
  logic         start    [NDUT];
  logic         busy     [NDUT];
  logic [W-1:0] ops      [NDUT][8];

  matmult_loader #(.WIDTH(W), .HOLD_CYCLES(H0)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a11(ops[0][0]), .a12(ops[0][1]), .a21(ops[0][2]), .a22(ops[0][3]),
    .b11(ops[0][4]), .b12(ops[0][5]), .b21(ops[0][6]), .b22(ops[0][7]),
    .op_valid(op_valid[0]), .start(start[0]), .busy(busy[0])
  );

  matmult_loader #(.WIDTH(W), .HOLD_CYCLES(H1)) u_dut12 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a11(ops[1][0]), .a12(ops[1][1]), .a21(ops[1][2]), .a22(ops[1][3]),
    .b11(ops[1][4]), .b12(ops[1][5]), .b21(ops[1][6]), .b22(ops[1][7]),
    .op_valid(op_valid[1]), .start(start[1]), .busy(busy[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: words accepted so far, sets transferred so far, and the edge of the last transfer.
  int           hold_p   [NDUT] = '{H0, H1};
  int           m_acc    [NDUT];
  int           m_xfer   [NDUT];
  int           m_last_t [NDUT];
  bit           m_has_t  [NDUT];
  bit           m_accepted [NDUT];
  logic [W-1:0] m_words  [NDUT][MAXW];
  logic [W-1:0] m_out    [NDUT][8];
  int           edge_n = 0;

  // Stimulus sources
  logic [W-1:0] src_buf [NDUT][64];
  int           src_n   [NDUT];
  int           src_p   [NDUT];

  function automatic bit m_set_waiting(input int d);
    return (m_acc[d] - 8 * m_xfer[d]) == 8;
  endfunction

  function automatic bit m_opv(input int d);
    return m_has_t[d] && (edge_n < m_last_t[d] + hold_p[d]);
  endfunction

  function automatic bit m_busy(input int d);
    return m_opv(d) || (m_acc[d] > 8 * m_xfer[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_acc[d] = 0; m_xfer[d] = 0; m_last_t[d] = 0; m_has_t[d] = 1'b0; m_accepted[d] = 1'b0;
      for (int i = 0; i < 8; i++) m_out[d][i] = '0;
    end
  endtask

  // One clock edge: decide from pre-edge state, advance model, then compare everything.
  task automatic tick();
    bit acc [NDUT];
    bit xf  [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      acc[d] = in_valid[d] && !m_set_waiting(d);
      xf[d]  = m_set_waiting(d) && (!m_has_t[d] || edge_n >= m_last_t[d] + hold_p[d]);
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (acc[d]) begin
        m_words[d][m_acc[d] % MAXW] = in_data[d];
        m_acc[d]++;
      end
      if (xf[d]) begin
        for (int i = 0; i < 8; i++) m_out[d][i] = m_words[d][(8 * m_xfer[d] + i) % MAXW];
        m_xfer[d]++;
        m_last_t[d] = edge_n;
        m_has_t[d]  = 1'b1;
      end
      m_accepted[d] = acc[d];
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_in_ready@%0d", d, edge_n), in_ready[d], !m_set_waiting(d));
      chk($sformatf("d%0d_start@%0d", d, edge_n), start[d], m_has_t[d] && (m_last_t[d] == edge_n));
      chk($sformatf("d%0d_op_valid@%0d", d, edge_n), op_valid[d], m_opv(d));
      chk($sformatf("d%0d_busy@%0d", d, edge_n), busy[d], m_busy(d));
      for (int i = 0; i < 8; i++)
        chk($sformatf("d%0d_op%0d@%0d", d, i, edge_n), ops[d][i], m_out[d][i]);
    end
    edge_n++;
  endtask

  // Drive both sources for n cycles; valid is asserted with probability pct when data remains.
  task automatic run(input int n, input int pct);
    for (int c = 0; c < n; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d] = (src_p[d] < src_n[d]) && ($urandom_range(99) < pct);
        in_data[d]  = in_valid[d] ? src_buf[d][src_p[d]] : $urandom;
      end
      tick();
      for (int d = 0; d < NDUT; d++) if (m_accepted[d]) src_p[d]++;
    end
  endtask

  task automatic load_src(input int d, input logic [W-1:0] first, input int n, input bit same);
    src_n[d] = n; src_p[d] = 0;
    for (int i = 0; i < n; i++) src_buf[d][i] = same ? first : first + W'(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin in_valid[d] = 1'b0; src_n[d] = 0; src_p[d] = 0; end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_rst_op_valid", d), op_valid[d], 1'b0);
      chk($sformatf("d%0d_rst_start", d), start[d], 1'b0);
      chk($sformatf("d%0d_rst_busy", d), busy[d], 1'b0);
      chk($sformatf("d%0d_rst_in_ready", d), in_ready[d], 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("d%0d_rst_op%0d", d, i), ops[d][i], '0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
    logic         rdy;
    logic         st;
    logic         opv;
    logic         bsy;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    int starts, opv_cycles, rises, cyc;
    bit prev_opv, done;

    // Idle load on the hold-4 instance: words 1..8 at edges 0..7, transfer at edge 8.
    for (int i = 0; i < 15; i++) begin
      tbl[i].vld = (i < 8);
      tbl[i].dat = W'(i + 1);
      tbl[i].rdy = (i != 7);
      tbl[i].st  = (i == 8);
      tbl[i].opv = (i >= 8) && (i <= 11);
      tbl[i].bsy = (i <= 11);
    end

    for (int d = 0; d < NDUT; d++) begin in_valid[d] = 1'b0; in_data[d] = '0; end
    do_reset();

    for (int i = 0; i < 15; i++) begin
      in_valid[0] = tbl[i].vld; in_data[0] = tbl[i].dat;
      in_valid[1] = 1'b0;       in_data[1] = '0;
      tick();
      chk($sformatf("tbl%0d_in_ready", i), in_ready[0], tbl[i].rdy);
      chk($sformatf("tbl%0d_start", i), start[0], tbl[i].st);
      chk($sformatf("tbl%0d_op_valid", i), op_valid[0], tbl[i].opv);
      chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].bsy);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("idle_load_op%0d", i), ops[0][i], W'(i + 1));

    // Reset mid-stream: 5 words in flight, then reset, then a fresh set 0xA..0x11.
    for (int d = 0; d < NDUT; d++) load_src(d, 32'h1, 5, 1'b0);
    run(5, 100);
    for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d_midstream_busy", d), busy[d], 1'b1);
    do_reset();
    for (int d = 0; d < NDUT; d++) load_src(d, 32'hA, 8, 1'b0);
    run(30, 100);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_post_rst_a11", d), ops[d][0], 32'hA);
      chk($sformatf("d%0d_post_rst_b22", d), ops[d][7], 32'h11);
    end

    // Back-to-back sets on the hold-12 instance.
    do_reset();
    for (int d = 0; d < NDUT; d++) load_src(d, 32'h1, 16, 1'b0);
    starts = 0; opv_cycles = 0; rises = 0; prev_opv = 1'b0;
    for (int c = 0; c < 45; c++) begin
      run(1, 100);
      if (start[1]) starts++;
      if (op_valid[1]) opv_cycles++;
      if (op_valid[1] && !prev_opv) rises++;
      prev_opv = op_valid[1];
    end
    chk("b2b_start_pulses", starts, 2);
    chk("b2b_op_valid_cycles", opv_cycles, 24);
    chk("b2b_op_valid_rises", rises, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_op%0d", i), ops[1][i], W'(i + 9));

    // Random backpressure over three sets per instance.
    do_reset();
    for (int d = 0; d < NDUT; d++) begin
      src_n[d] = 24; src_p[d] = 0;
      for (int i = 0; i < 24; i++) src_buf[d][i] = $urandom;
    end
    cyc = 0; done = 1'b0;
    while (!done && cyc < 800) begin
      run(1, 45);
      cyc++;
      done = 1'b1;
      for (int d = 0; d < NDUT; d++)
        if (src_p[d] < src_n[d] || m_busy(d)) done = 1'b0;
    end
    chk("rand_completed", done, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_rand_sets", d), m_xfer[d], 3);
      chk($sformatf("d%0d_rand_a11", d), ops[d][0], src_buf[d][16]);
      chk($sformatf("d%0d_rand_b22", d), ops[d][7], src_buf[d][23]);
    end

    // Hold with no new data.
    do_reset();
    for (int d = 0; d < NDUT; d++) load_src(d, 32'hFFFF_FFFF, 8, 1'b1);
    run(35, 100);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_hold_op_valid", d), op_valid[d], 1'b0);
      chk($sformatf("d%0d_hold_start", d), start[d], 1'b0);
      chk($sformatf("d%0d_hold_in_ready", d), in_ready[d], 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("d%0d_hold_op%0d", d, i), ops[d][i], 32'hFFFF_FFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
